// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - response tracker states and requester ids for sram_arbiter
// Shared by the arbiter top; SRAM_ARB_RR_EN selects the round-robin build.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_RESP_INST = 2'd1,
      ARB_RESP_DATA = 2'd2
   } arb_state_t;

   localparam logic REQ_INST = 1'b0;
   localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/sram_arbiter_arb_pick.sv
// rtl/sram_arbiter_arb_pick.sv - combinational winner select between inst and data requests
// inst_pri decides conflicts only; a sole requester is always granted.
module arb_pick (
   input  logic inst_req,
   input  logic data_req,
   input  logic inst_pri,
   output logic inst_gnt,
   output logic data_gnt
);

   assign inst_gnt = inst_req & (~data_req | inst_pri);
   assign data_gnt = data_req & ~(inst_req & inst_pri);

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port SRAM between fetch and data requesters
// Define SRAM_ARB_RR_EN for round-robin conflicts; default is data priority with inst starvation guard.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_WD    = 32,
   parameter int DATA_WD    = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inst_req,
   input  logic [3:0]         inst_we,
   input  logic [ADDR_WD-1:0] inst_addr,
   input  logic [DATA_WD-1:0] inst_wdata,
   output logic               inst_gnt,
   output logic               inst_rvalid,
   output logic [DATA_WD-1:0] inst_rdata,
   input  logic               data_req,
   input  logic [3:0]         data_we,
   input  logic [ADDR_WD-1:0] data_addr,
   input  logic [DATA_WD-1:0] data_wdata,
   output logic               data_gnt,
   output logic               data_rvalid,
   output logic [DATA_WD-1:0] data_rdata,
   output logic               sram_en,
   output logic [3:0]         sram_we,
   output logic [ADDR_WD-1:0] sram_addr,
   output logic [DATA_WD-1:0] sram_wdata,
   input  logic [DATA_WD-1:0] sram_rdata
);

   arb_state_t state, state_nxt;
   logic       inst_pri;
   logic       inst_req_live;
   logic       data_req_live;

   // Requests are masked while reset is high so nothing reaches the SRAM port.
   assign inst_req_live = inst_req & ~reset;
   assign data_req_live = data_req & ~reset;

   arb_pick u_arb_pick (
      .inst_req (inst_req_live),
      .data_req (data_req_live),
      .inst_pri (inst_pri),
      .inst_gnt (inst_gnt),
      .data_gnt (data_gnt)
   );

`ifdef SRAM_ARB_RR_EN
   logic last_gnt;

   assign inst_pri = (last_gnt == REQ_DATA);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt <= REQ_DATA;
      end else if (inst_gnt) begin
         last_gnt <= REQ_INST;
      end else if (data_gnt) begin
         last_gnt <= REQ_DATA;
      end
   end
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;

   assign inst_pri = (starve_cnt == STARVE_LIM);

   // Counts consecutive denied inst requests; saturates rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= 4'd0;
      end else if (!inst_req || inst_gnt) begin
         starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'hf) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = ARB_IDLE;
      if (inst_gnt && inst_we == 4'h0) begin
         state_nxt = ARB_RESP_INST;
      end else if (data_gnt && data_we == 4'h0) begin
         state_nxt = ARB_RESP_DATA;
      end
   end

   assign inst_rvalid = (state == ARB_RESP_INST);
   assign data_rvalid = (state == ARB_RESP_DATA);
   assign inst_rdata  = sram_rdata;
   assign data_rdata  = sram_rdata;

   always_comb begin
      sram_en    = inst_gnt | data_gnt;
      sram_we    = 4'h0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (inst_gnt) begin
         sram_we    = inst_we;
         sram_addr  = inst_addr;
         sram_wdata = inst_wdata;
      end else if (data_gnt) begin
         sram_we    = data_we;
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed scoreboard bench for sram_arbiter
// Builds for either policy; SRAM_ARB_RR_EN selects round-robin expectations.
module tb_sram_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] MAGIC = 32'h5a5a_c3c3;

   logic          clk = 1'b0;
   logic          reset;
   logic          inst_req, data_req;
   logic [3:0]    inst_we, data_we;
   logic [AW-1:0] inst_addr, data_addr;
   logic [DW-1:0] inst_wdata, data_wdata;
   logic          inst_gnt, data_gnt, inst_rvalid, data_rvalid;
   logic [DW-1:0] inst_rdata, data_rdata;
   logic          sram_en;
   logic [3:0]    sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata = '0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic        is_inst;
      logic [31:0] data;
      int          due;
   } resp_t;
   resp_t sb[$];

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_WD(AW), .DATA_WD(DW), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_we(inst_we), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   // SRAM model: a read returns a pattern derived from its address one cycle later.
   always @(posedge clk) begin
      if (sram_en && sram_we == 4'h0) sram_rdata <= sram_addr ^ MAGIC;
      else                            sram_rdata <= 32'hdead_beef;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [3:0] iw, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dw, input logic [31:0] da);
      inst_req   = ir;
      inst_we    = iw;
      inst_addr  = ia;
      inst_wdata = ia ^ 32'h0f0f_0000;
      data_req   = dr;
      data_we    = dw;
      data_addr  = da;
      data_wdata = da ^ 32'h00f0_f0f0;
   endtask

   task automatic step(input string tag, input logic exp_ig, input logic exp_dg);
      resp_t r;
      @(negedge clk);
      chk({tag, ".inst_gnt"}, {31'd0, inst_gnt}, {31'd0, exp_ig});
      chk({tag, ".data_gnt"}, {31'd0, data_gnt}, {31'd0, exp_dg});
      chk({tag, ".sram_en"}, {31'd0, sram_en}, {31'd0, exp_ig | exp_dg});
      if (exp_ig) begin
         chk({tag, ".addr"}, sram_addr, inst_addr);
         chk({tag, ".we"}, {28'd0, sram_we}, {28'd0, inst_we});
      end else if (exp_dg) begin
         chk({tag, ".addr"}, sram_addr, data_addr);
         chk({tag, ".we"}, {28'd0, sram_we}, {28'd0, data_we});
         chk({tag, ".wdata"}, sram_wdata, data_wdata);
      end else begin
         chk({tag, ".addr"}, sram_addr, 32'd0);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         r = sb.pop_front();
         chk({tag, ".inst_rvalid"}, {31'd0, inst_rvalid}, {31'd0, r.is_inst});
         chk({tag, ".data_rvalid"}, {31'd0, data_rvalid}, {31'd0, ~r.is_inst});
         chk({tag, ".rdata"}, r.is_inst ? inst_rdata : data_rdata, r.data);
      end else begin
         chk({tag, ".no_rvalid"}, {30'd0, inst_rvalid, data_rvalid}, 32'd0);
      end
      if (exp_ig && inst_we == 4'h0) sb.push_back('{1'b1, inst_addr ^ MAGIC, cyc + 1});
      if (exp_dg && data_we == 4'h0) sb.push_back('{1'b0, data_addr ^ MAGIC, cyc + 1});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc++;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b1, 4'h0, 32'h1c00_0000, 1'b1, 4'h0, 32'h0000_2000);
      @(negedge clk);
      chk("rst.gnt", {30'd0, inst_gnt, data_gnt}, 32'd0);
      chk("rst.sram_en", {31'd0, sram_en}, 32'd0);
      chk("rst.sram_we", {28'd0, sram_we}, 32'd0);
      chk("rst.sram_addr", sram_addr, 32'd0);
      chk("rst.rvalid", {30'd0, inst_rvalid, data_rvalid}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      drive(1'b1, 4'h0, 32'h1c00_0000, 1'b0, 4'h0, 32'h0);
      step("inst_only", 1'b1, 1'b0);
      drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      step("idle0", 1'b0, 1'b0);

`ifdef SRAM_ARB_RR_EN
      pulse_reset();
      drive(1'b1, 4'h0, 32'h1c00_0040, 1'b1, 4'h0, 32'h0000_2040);
      for (int i = 0; i < 6; i++) begin
         step($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
      end
      drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      step("idle_rr", 1'b0, 1'b0);
`else
      drive(1'b1, 4'h0, 32'h1c00_0004, 1'b1, 4'h0, 32'h0000_2000);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("starve%0d", i), (i % 5) == 4, (i % 5) != 4);
      end

      drive(1'b1, 4'h0, 32'h1c00_0010, 1'b1, 4'hf, 32'h0000_0100);
      step("wr_conflict", 1'b0, 1'b1);
      drive(1'b1, 4'h0, 32'h1c00_0010, 1'b0, 4'h0, 32'h0);
      step("wr_after", 1'b1, 1'b0);
      drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      step("idle1", 1'b0, 1'b0);

      drive(1'b1, 4'h0, 32'h1c00_0020, 1'b1, 4'h0, 32'h0000_3000);
      step("wd0", 1'b0, 1'b1);
      step("wd1", 1'b0, 1'b1);
      drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h0000_3004);
      step("wd_withdraw", 1'b0, 1'b1);
      drive(1'b1, 4'h0, 32'h1c00_0024, 1'b1, 4'h0, 32'h0000_3008);
      for (int i = 0; i < 5; i++) begin
         step($sformatf("wd_again%0d", i), i == 4, i != 4);
      end
      drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      step("idle2", 1'b0, 1'b0);
`endif

      // A data read is granted, then reset rises before the edge that would register it.
      drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h0000_4000);
      @(negedge clk);
      chk("mid.data_gnt", {31'd0, data_gnt}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid.gnt_drop", {30'd0, inst_gnt, data_gnt}, 32'd0);
      chk("mid.sram_en_drop", {31'd0, sram_en}, 32'd0);
      @(posedge clk);
      #1;
      chk("mid.no_rvalid_rst", {30'd0, inst_rvalid, data_rvalid}, 32'd0);
      reset = 1'b0;
      cyc++;
      drive(1'b1, 4'h0, 32'h1c00_0080, 1'b0, 4'h0, 32'h0);
      step("post_rst", 1'b1, 1'b0);
      drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      step("post_rst_resp", 1'b0, 1'b0);
      step("idle_end", 1'b0, 1'b0);

      chk("sb_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
